// File: rtl/mire_pkg.sv
// Shared types and constants for the test-pattern frame writer.
package mire_pkg;

   // Bus master states
   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StPause
   } mire_state_e;

   localparam int unsigned PIXEL_BYTES = 4;
   localparam logic [3:0]  GRID_MASK   = 4'hF;
   localparam logic [31:0] WHITE       = 32'h00FF_FFFF;
   localparam logic [31:0] BLACK       = 32'h0000_0000;

   // Counter width for values 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Grid pattern: white on every 16th column and every 16th row
   function automatic logic [31:0] grid_pixel(input logic [3:0] x_lsb, input logic [3:0] y_lsb);
      return (((x_lsb & GRID_MASK) == 4'h0) || ((y_lsb & GRID_MASK) == 4'h0)) ? WHITE : BLACK;
   endfunction

endpackage

// File: rtl/pix_xy_cnt.sv
// Raster position counter: x runs across a line, y down the frame, both wrap at
// the end of the frame.
module pix_xy_cnt
   import mire_pkg::*;
#(
   parameter int unsigned HDISP = 800,
   parameter int unsigned VDISP = 480,
   parameter int unsigned XW    = cnt_width(HDISP),
   parameter int unsigned YW    = cnt_width(VDISP)
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          advance,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          eof
);

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          x_last;
   logic          y_last;

   assign x_last = (x_q == XW'(HDISP - 1));
   assign y_last = (y_q == YW'(VDISP - 1));

   // Step one pixel per advance, wrapping line then frame
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else if (advance) begin
         if (x_last) begin
            x_q <= '0;
            if (y_last) begin
               y_q <= '0;
            end else begin
               y_q <= y_q + 1'b1;
            end
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   assign x   = x_q;
   assign y   = y_q;
   assign eof = x_last && y_last;

endmodule

// File: rtl/mire_writer.sv
// Writes a 16-pixel white-grid-on-black test pattern into an SDRAM frame buffer
// over a classic-cycle Wishbone master, in bounded bursts separated by pauses.
module mire_writer
   import mire_pkg::*;
#(
   parameter int unsigned HDISP = 800,
   parameter int unsigned VDISP = 480,
   parameter int unsigned BURST = 64,
   parameter int unsigned PAUSE = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        enable,
   // Wishbone master toward the frame buffer
   output logic        cyc,
   output logic        stb,
   output logic        we,
   output logic [31:0] adr,
   output logic [31:0] dat_ms,
   output logic [3:0]  sel,
   output logic [2:0]  cti,
   output logic [1:0]  bte,
   input  logic        ack,
   input  logic        err,
   input  logic        rty,
   input  logic [31:0] dat_sm,
   output logic        frame_done
);

   localparam int unsigned XW = cnt_width(HDISP);
   localparam int unsigned YW = cnt_width(VDISP);
   localparam int unsigned BW = cnt_width(BURST + 1);
   localparam int unsigned PW = cnt_width(PAUSE + 1);

   mire_state_e   state_q, state_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [PW-1:0] pause_q, pause_d;
   logic          frame_done_q, frame_done_d;

   logic          advance;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          eof;
   logic          in_write;
   logic          last_pause;
   logic [31:0]   pix_index;

   // Write-only master: read data is never consumed
   logic          unused_dat_sm;
   assign unused_dat_sm = ^dat_sm;

   pix_xy_cnt #(
      .HDISP (HDISP),
      .VDISP (VDISP),
      .XW    (XW),
      .YW    (YW)
   ) u_pix_xy_cnt (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .advance   (advance),
      .x         (x),
      .y         (y),
      .eof       (eof)
   );

   // A PAUSE of zero still costs one idle cycle so stb always drops after a tenure
   assign last_pause = (32'(pause_q) + 32'd1) >= PAUSE;

   // State, burst beat, pause and frame-done registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= StIdle;
         beat_q       <= '0;
         pause_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         pause_q      <= pause_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state: the pixel position only moves on an accepted write; err/rty
   // leave it in place so the same address is retried after the pause
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      pause_d      = pause_q;
      frame_done_d = 1'b0;
      advance      = 1'b0;
      unique case (state_q)
         StIdle: begin
            beat_d  = '0;
            pause_d = '0;
            if (enable) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (ack) begin
               advance      = 1'b1;
               beat_d       = beat_q + 1'b1;
               frame_done_d = eof;
               if ((beat_d == BW'(BURST)) || eof || !enable) begin
                  state_d = StPause;
                  pause_d = '0;
               end
            end else if (err || rty) begin
               state_d = StPause;
               pause_d = '0;
            end
         end
         StPause: begin
            beat_d = '0;
            if (last_pause) begin
               pause_d = '0;
               state_d = enable ? StWrite : StIdle;
            end else begin
               pause_d = pause_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign pix_index = 32'(y) * HDISP + 32'(x);

   // Bus outputs decode from registered state, so reset clears them immediately
   // and adr/dat_ms hold steady for as long as the slave stalls
   always_comb begin
      in_write = (state_q == StWrite);
      cyc      = in_write;
      stb      = in_write;
      we       = in_write;
      sel      = in_write ? 4'hF : 4'h0;
      cti      = 3'b000;
      bte      = 2'b00;
      adr      = in_write ? pix_index * PIXEL_BYTES : 32'h0;
      dat_ms   = in_write ? grid_pixel(4'(x), 4'(y)) : BLACK;
   end

   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mire_writer.sv
// Directed bench for mire_writer on a tiny 8x4 frame with a Wishbone slave model.
module tb_mire_writer;

   localparam int unsigned HDISP = 8;
   localparam int unsigned VDISP = 4;
   localparam int unsigned BURST = 4;
   localparam int unsigned PAUSE = 2;
   localparam logic [31:0] WHITE = 32'h00FF_FFFF;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_ms;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack = 1'b0;
   logic        err = 1'b0;
   logic        rty = 1'b0;
   logic [31:0] dat_sm = 32'h0;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // Slave model state
   bit          slave_en = 1'b1;
   logic [31:0] rty_adr = '1;
   logic [31:0] err_adr = '1;
   logic [31:0] slow_adr = '1;
   int          slow_delay = 3;
   int          wait_cnt = 0;
   int          rty_seen = 0;
   int          fd_count = 0;
   int          fd_at = -1;
   logic [31:0] log_adr[$];
   logic [31:0] log_dat[$];

   mire_writer #(
      .HDISP (HDISP),
      .VDISP (VDISP),
      .BURST (BURST),
      .PAUSE (PAUSE)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .enable     (enable),
      .cyc        (cyc),
      .stb        (stb),
      .we         (we),
      .adr        (adr),
      .dat_ms     (dat_ms),
      .sel        (sel),
      .cti        (cti),
      .bte        (bte),
      .ack        (ack),
      .err        (err),
      .rty        (rty),
      .dat_sm     (dat_sm),
      .frame_done (frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   // Slave: answers one cycle after stb (longer for slow_adr); logs accepted writes
   always @(negedge sys_clk) begin
      int delay;
      if (frame_done) begin
         fd_count++;
         fd_at = log_adr.size();
      end
      if (slave_en) begin
         ack = 1'b0;
         err = 1'b0;
         rty = 1'b0;
         if (!sys_rst_n || !(cyc && stb)) begin
            wait_cnt = 0;
         end else begin
            delay = (adr == slow_adr) ? slow_delay : 1;
            if (wait_cnt < delay) begin
               wait_cnt++;
            end else begin
               wait_cnt = 0;
               if (adr == rty_adr) begin
                  rty = 1'b1;
                  rty_adr = '1;
                  rty_seen++;
               end else if (adr == err_adr) begin
                  err = 1'b1;
                  err_adr = '1;
               end else begin
                  ack = 1'b1;
                  log_adr.push_back(adr);
                  log_dat.push_back(dat_ms);
               end
            end
         end
      end
   end

   function automatic logic [31:0] exp_dat(input int i);
      int x, y;
      x = i % HDISP;
      y = i / HDISP;
      return ((x % 16 == 0) || (y % 16 == 0)) ? WHITE : 32'h0;
   endfunction

   task automatic step();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic wait_cyc(input logic level, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (cyc === level) begin
            ok = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic do_reset(input logic en);
      sys_rst_n = 1'b0;
      enable    = en;
      rty_adr   = '1;
      err_adr   = '1;
      slow_adr  = '1;
      step();
      step();
      log_adr.delete();
      log_dat.delete();
      fd_count  = 0;
      fd_at     = -1;
      rty_seen  = 0;
      sys_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      enable    = 1'b1;
      step();
      step();
      checks++;
      if (cyc !== 1'b0 || stb !== 1'b0 || we !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got cyc=%b stb=%b we=%b want 0 0 0", cyc, stb, we);
      end
      checks++;
      if (adr !== 32'h0) begin
         errors++;
         $display("FAIL reset_adr got %h want 0", adr);
      end
      checks++;
      if (dat_ms !== 32'h0 || sel !== 4'h0) begin
         errors++;
         $display("FAIL reset_dat_sel got %h/%h want 0/0", dat_ms, sel);
      end
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_frame_done got %b want 0", frame_done);
      end
   endtask

   task automatic test_spurious_ack();
      bit ok;
      int hi;
      do_reset(1'b0);
      step();
      slave_en = 1'b0;
      ack = 1'b1;
      err = 1'b1;
      rty = 1'b1;
      hi = 0;
      repeat (3) begin
         step();
         if (cyc || frame_done) hi++;
      end
      ack = 1'b0;
      err = 1'b0;
      rty = 1'b0;
      slave_en = 1'b1;
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL idle_spurious_cyc got %0d active cycles want 0", hi);
      end
      enable = 1'b1;
      wait_cyc(1'b1, ok);
      checks++;
      if (!ok || adr !== 32'h0) begin
         errors++;
         $display("FAIL idle_spurious_adr got ok=%b adr=%h want 1 0", ok, adr);
      end
   endtask

   task automatic test_first_burst();
      bit ok;
      int n;
      do_reset(1'b1);
      wait_cyc(1'b1, ok);
      checks++;
      if (!ok || adr !== 32'h0 || dat_ms !== WHITE) begin
         errors++;
         $display("FAIL first_write got ok=%b adr=%h dat=%h want 1 0 %h", ok, adr, dat_ms, WHITE);
      end
      checks++;
      if (stb !== 1'b1 || we !== 1'b1 || sel !== 4'hF || cti !== 3'b000 || bte !== 2'b00) begin
         errors++;
         $display("FAIL first_ctrl got stb=%b we=%b sel=%h cti=%b bte=%b want 1 1 f 000 00",
                  stb, we, sel, cti, bte);
      end
      wait_cyc(1'b0, ok);
      checks++;
      if (!ok || log_adr.size() != 4) begin
         errors++;
         $display("FAIL burst_len got ok=%b writes=%0d want 1 4", ok, log_adr.size());
      end
      n = 0;
      while (cyc === 1'b0 && n < 20) begin
         n++;
         step();
      end
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL pause_len got %0d want 2", n);
      end
      checks++;
      if (adr !== 32'd16) begin
         errors++;
         $display("FAIL burst2_adr got %h want 10", adr);
      end
   endtask

   task automatic test_full_frame();
      bit ok;
      int bad;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (fd_count >= 1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!ok || fd_at != 32) begin
         errors++;
         $display("FAIL frame_done_pos got ok=%b writes=%0d want 1 32", ok, fd_at);
      end
      bad = 0;
      for (int i = 0; i < log_adr.size() && i < 32; i++) begin
         if (log_adr[i] !== 32'(4 * i) || log_dat[i] !== exp_dat(i)) bad++;
      end
      checks++;
      if (bad != 0 || log_adr.size() < 32) begin
         errors++;
         $display("FAIL frame_log got %0d bad of %0d want 0 of 32", bad, log_adr.size());
      end
      checks++;
      if (log_dat.size() < 25 || log_dat[9] !== 32'h0 || log_dat[24] !== WHITE) begin
         errors++;
         $display("FAIL pixel_1_1_0_3 got size=%0d want (1,1)=0 (0,3)=%h", log_dat.size(), WHITE);
      end
      wait_cyc(1'b1, ok);
      checks++;
      if (!ok || adr !== 32'h0) begin
         errors++;
         $display("FAIL frame_wrap_adr got ok=%b adr=%h want 1 0", ok, adr);
      end
      checks++;
      if (fd_count != 1) begin
         errors++;
         $display("FAIL frame_done_pulses got %0d want 1", fd_count);
      end
   endtask

   task automatic test_retry();
      bit ok;
      int n;
      int bad;
      do_reset(1'b1);
      rty_adr = 32'd20;
      err_adr = 32'd60;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (rty_seen != 0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      wait_cyc(1'b0, ok);
      n = 0;
      while (cyc === 1'b0 && n < 20) begin
         n++;
         step();
      end
      checks++;
      if (!ok || n != 2) begin
         errors++;
         $display("FAIL rty_pause got ok=%b cycles=%0d want 1 2", ok, n);
      end
      checks++;
      if (adr !== 32'd20) begin
         errors++;
         $display("FAIL rty_reissue got %h want 14", adr);
      end
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (fd_count >= 1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      bad = 0;
      for (int i = 0; i < log_adr.size(); i++) begin
         if (log_adr[i] !== 32'(4 * i)) bad++;
      end
      checks++;
      if (!ok || log_adr.size() != 32 || bad != 0) begin
         errors++;
         $display("FAIL retry_log got ok=%b writes=%0d bad=%0d want 1 32 0",
                  ok, log_adr.size(), bad);
      end
   endtask

   task automatic test_enable_drop();
      bit ok;
      bit got;
      int bad;
      int hi;
      do_reset(1'b1);
      slow_adr = 32'd8;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cyc === 1'b1 && stb === 1'b1 && adr === 32'd8) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      enable = 1'b0;
      got = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (log_adr.size() == 3) begin
            got = 1'b1;
            break;
         end
         if (!(cyc === 1'b1 && stb === 1'b1 && adr === 32'd8)) bad++;
         step();
      end
      checks++;
      if (!ok || !got || bad != 0) begin
         errors++;
         $display("FAIL en_drop_hold got ok=%b acked=%b drops=%0d want 1 1 0", ok, got, bad);
      end
      checks++;
      if (log_adr.size() != 3 || log_adr[2] !== 32'd8) begin
         errors++;
         $display("FAIL en_drop_last got writes=%0d want 3 ending at 8", log_adr.size());
      end
      hi = 0;
      repeat (10) begin
         step();
         if (cyc !== 1'b0) hi++;
      end
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL en_drop_idle got %0d active cycles want 0", hi);
      end
      slow_adr = '1;
      enable = 1'b1;
      wait_cyc(1'b1, ok);
      checks++;
      if (!ok || adr !== 32'd12 || dat_ms !== WHITE) begin
         errors++;
         $display("FAIL en_resume got ok=%b adr=%h dat=%h want 1 c %h", ok, adr, dat_ms, WHITE);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset(1'b1);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (log_adr.size() >= 2 && cyc === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (!ok || cyc !== 1'b0 || stb !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_drop got ok=%b cyc=%b stb=%b want 1 0 0", ok, cyc, stb);
      end
      step();
      log_adr.delete();
      log_dat.delete();
      sys_rst_n = 1'b1;
      wait_cyc(1'b1, ok);
      checks++;
      if (!ok || adr !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_restart got ok=%b adr=%h want 1 0", ok, adr);
      end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (log_adr.size() >= 1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!ok || log_adr[0] !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_first_ack got ok=%b want first acked adr 0", ok);
      end
   endtask

   initial begin
      test_reset();
      test_spurious_ack();
      test_first_burst();
      test_full_frame();
      test_retry();
      test_enable_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
